// File: rtl/einsum_lse_add_pipe.sv
// Multi-lane 3-stage log-sum-exp adder: lse(a,b) = max(a,b) + LUT[|a-b| >> IDX_SHIFT],
// with max-only and bypass modes, NEG_INF handling and positive saturation.
module einsum_lse_add_pipe #(
  parameter int LANES     = 4,
  parameter int DATA_W    = 24,
  parameter int FRAC_W    = 10,
  parameter int LUT_AW    = 4,
  parameter int LUT_PREC  = 10,
  parameter int IDX_SHIFT = 8,
  parameter int TAG_W     = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [1:0]                i_mode,
  input  logic [LANES*DATA_W-1:0]   i_op_a,
  input  logic [LANES*DATA_W-1:0]   i_op_b,
  input  logic [TAG_W-1:0]          i_tag,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [LANES*DATA_W-1:0]   o_sum,
  output logic [LANES-1:0]          o_sat,
  output logic [TAG_W-1:0]          o_tag,
  input  logic                      i_lut_we,
  input  logic [LUT_AW-1:0]         i_lut_addr,
  input  logic [LUT_PREC-1:0]       i_lut_wdata
);

  localparam int LUT_SIZE = 2 ** LUT_AW;
  localparam logic [DATA_W:0]   LUT_SIZE_W = (DATA_W+1)'(LUT_SIZE);
  localparam logic [DATA_W-1:0] NEG_INF = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};

  logic adv;
  logic [1:0] mode_in;

  // Stage 1
  logic                           v1_reg;
  logic [1:0]                     mode1_reg;
  logic [TAG_W-1:0]               tag1_reg;
  logic [LANES-1:0][DATA_W-1:0]   max1_reg, max1_next;
  logic [LANES-1:0][DATA_W:0]     d1_reg, d1_next;
  logic [LANES-1:0]               inf1_reg, inf1_next;

  // Stage 2
  logic                           v2_reg;
  logic [TAG_W-1:0]               tag2_reg;
  logic [LANES-1:0][DATA_W-1:0]   max2_reg;
  logic [LANES-1:0][LUT_PREC-1:0] corr2_reg, corr2_next;

  // Stage 3 (output register)
  logic                           o_valid_reg;
  logic [LANES*DATA_W-1:0]        o_sum_reg, sum3_next;
  logic [LANES-1:0]               o_sat_reg, sat3_next;
  logic [TAG_W-1:0]               o_tag_reg;

  logic [LUT_PREC-1:0] lut_mem [LUT_SIZE];

  assign adv     = !o_valid_reg || i_ready;
  assign o_ready = adv;
  assign o_valid = o_valid_reg;
  assign o_sum   = o_sum_reg;
  assign o_sat   = o_sat_reg;
  assign o_tag   = o_tag_reg;

  // Reserved mode 11 behaves exactly like lse, so it is normalised on entry.
  assign mode_in = (i_mode == 2'b11) ? 2'b00 : i_mode;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [DATA_W-1:0] a, b, mx, mn;
    logic              a_ge_b;
    logic [DATA_W:0]   idx_full;
    logic [DATA_W:0]   sum;

    assign a      = i_op_a[gi*DATA_W +: DATA_W];
    assign b      = i_op_b[gi*DATA_W +: DATA_W];
    assign a_ge_b = $signed(a) >= $signed(b);
    assign mx     = a_ge_b ? a : b;
    assign mn     = a_ge_b ? b : a;

    // Bypass reuses the max path with operand a and a zero correction.
    assign max1_next[gi] = (mode_in == 2'b10) ? a : mx;
    assign d1_next[gi]   = {mx[DATA_W-1], mx} - {mn[DATA_W-1], mn};
    // NEG_INF is the most negative code, so max already picks the other operand.
    assign inf1_next[gi] = (a == NEG_INF) || (b == NEG_INF);

    assign idx_full = d1_reg[gi] >> IDX_SHIFT;
    assign corr2_next[gi] = (mode1_reg == 2'b00 && !inf1_reg[gi] && idx_full < LUT_SIZE_W)
                            ? lut_mem[idx_full[LUT_AW-1:0]] : '0;

    // corr is small and non-negative, so only positive overflow into bit DATA_W-1 is possible.
    assign sum = {max2_reg[gi][DATA_W-1], max2_reg[gi]} + (DATA_W+1)'(corr2_reg[gi]);
    assign sat3_next[gi] = !sum[DATA_W] && sum[DATA_W-1];
    assign sum3_next[gi*DATA_W +: DATA_W] = sat3_next[gi] ? MAX_POS : sum[DATA_W-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1_reg      <= 1'b0;
      v2_reg      <= 1'b0;
      o_valid_reg <= 1'b0;
      o_sum_reg   <= '0;
      o_sat_reg   <= '0;
      o_tag_reg   <= '0;
    end else if (adv) begin
      v1_reg    <= i_valid;
      mode1_reg <= mode_in;
      tag1_reg  <= i_tag;
      max1_reg  <= max1_next;
      d1_reg    <= d1_next;
      inf1_reg  <= inf1_next;

      v2_reg    <= v1_reg;
      tag2_reg  <= tag1_reg;
      max2_reg  <= max1_reg;
      corr2_reg <= corr2_next;

      o_valid_reg <= v2_reg;
      if (v2_reg) begin
        o_sum_reg <= sum3_next;
        o_sat_reg <= sat3_next;
        o_tag_reg <= tag2_reg;
      end
    end
  end

  // Writes ignore backpressure; a same-cycle read in stage 2 sees the old entry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < LUT_SIZE; i++) lut_mem[i] <= '0;
    end else if (i_lut_we) begin
      lut_mem[i_lut_addr] <= i_lut_wdata;
    end
  end

endmodule

// File: tb/tb_einsum_lse_add_pipe.sv
// Scoreboard bench for einsum_lse_add_pipe: driver pushes expected beats, a negedge
// monitor pops and compares whenever a beat transfers out.
module tb_einsum_lse_add_pipe;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_mode;
  logic [95:0] i_op_a, i_op_b;
  logic [7:0]  i_tag;
  logic        o_valid;
  logic        i_ready;
  logic [95:0] o_sum;
  logic [3:0]  o_sat;
  logic [7:0]  o_tag;
  logic        i_lut_we;
  logic [3:0]  i_lut_addr;
  logic [9:0]  i_lut_wdata;

  einsum_lse_add_pipe dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_mode(i_mode), .i_op_a(i_op_a), .i_op_b(i_op_b), .i_tag(i_tag),
    .o_valid(o_valid), .i_ready(i_ready), .o_sum(o_sum), .o_sat(o_sat),
    .o_tag(o_tag), .i_lut_we(i_lut_we), .i_lut_addr(i_lut_addr),
    .i_lut_wdata(i_lut_wdata)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [95:0] sum;
    logic [3:0]  sat;
    logic [7:0]  tag;
    bit          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic [95:0] hold_sum;
  logic [7:0]  hold_tag;
  bit   held = 0;
  bit   saw_low;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic [95:0] pk(input logic [23:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  // Monitor: one line per transferred beat.
  always @(negedge i_clk) begin
    if (o_valid === 1'b1 && i_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got tag %h sum %h want no beat", o_tag, o_sum);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("beat tag=%h sum=%h sat=%h", o_tag, o_sum, o_sat);
        chk("sum", o_sum, e.sum);
        chk("sat", o_sat, e.sat);
        chk("tag", o_tag, e.tag);
        // acc is sampled just after the accepting edge, so t+3 shows up as +2 here.
        if (e.lat) chk("latency", cyc - e.acc, 2);
      end
    end
    if (o_valid === 1'b1 && i_ready === 1'b0) begin
      if (held) begin
        chk("stall_sum", o_sum, hold_sum);
        chk("stall_tag", o_tag, hold_tag);
      end
      hold_sum = o_sum;
      hold_tag = o_tag;
      held = 1;
    end else begin
      held = 0;
    end
  end

  task automatic send(input logic [1:0] m, input logic [95:0] a, input logic [95:0] b,
                      input logic [7:0] tg, input logic [95:0] es, input logic [3:0] esat,
                      input bit push, input bit lat);
    bit acc = 0;
    int n = 0;
    exp_t e;
    i_mode = m; i_op_a = a; i_op_b = b; i_tag = tg; i_valid = 1'b1;
    while (!acc) begin
      @(negedge i_clk);
      acc = (o_ready === 1'b1);
      @(posedge i_clk);
      #1;
      n++;
      if (!acc && n > 40) begin
        total++;
        bad++;
        $display("FAIL send_timeout: got o_ready low for %0d cycles want accept", n);
        break;
      end
    end
    if (acc && push) begin
      e.sum = es; e.sat = esat; e.tag = tg; e.lat = lat; e.acc = cyc;
      exp_q.push_back(e);
    end
    i_valid = 1'b0;
  endtask

  task automatic lut_write(input logic [3:0] addr, input logic [9:0] data);
    i_lut_we = 1'b1; i_lut_addr = addr; i_lut_wdata = data;
    @(posedge i_clk);
    #1;
    i_lut_we = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge i_clk);
      n++;
    end
    #1;
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    logic [95:0] z;
    logic [95:0] pm;
    z = '0;
    pm = pk(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF);
    i_rst = 1'b1; i_valid = 1'b0; i_mode = 2'b00; i_op_a = '0; i_op_b = '0;
    i_tag = '0; i_ready = 1'b1; i_lut_we = 1'b0; i_lut_addr = '0; i_lut_wdata = '0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    chk("rst_valid", o_valid, 0);
    chk("rst_sum", o_sum, 0);
    chk("rst_sat", o_sat, 0);
    chk("rst_tag", o_tag, 0);
    chk("rst_ready", o_ready, 1);

    lut_write(4'd0, 10'd710);
    lut_write(4'd8, 10'd130);
    lut_write(4'd15, 10'd77);

    // Basic lse, boundaries, NEG_INF, saturation and modes, back to back.
    send(2'b00, z, z, 8'h11, pk(24'd710, 24'd710, 24'd710, 24'd710), 4'h0, 1, 1);
    send(2'b00, pk(24'd2048, 24'd0, 24'h800000, 24'h800000),
                pk(24'd0, 24'd5000, 24'h000400, 24'h800000), 8'h22,
                pk(24'd2178, 24'd5000, 24'h000400, 24'h800000), 4'h0, 1, 1);
    send(2'b00, pk(24'hFFF448, 24'd100, 24'd1000, 24'd3840),
                pk(24'hFFF448, 24'd356, 24'hFFFBE8, 24'd0), 8'h33,
                pk(24'hFFF70E, 24'd356, 24'd1130, 24'd3917), 4'h0, 1, 1);
    send(2'b00, pk(24'd4096, 24'h000400, 24'h7FFFFF, 24'hFFFFFB),
                pk(24'd0, 24'h800000, 24'h7FFFF0, 24'hFFFFFB), 8'h44,
                pk(24'd4096, 24'h000400, 24'h7FFFFF, 24'h0002C1), 4'b0100, 1, 1);
    send(2'b00, pm, pm, 8'h55, pm, 4'hF, 1, 1);
    send(2'b01, pm, pm, 8'h66, pm, 4'h0, 1, 1);
    send(2'b10, pk(24'h123456, 24'h800000, 24'h123456, 24'h123456),
                pk(24'h7FFFFF, 24'd5, 24'h7FFFFF, 24'h7FFFFF), 8'h77,
                pk(24'h123456, 24'h800000, 24'h123456, 24'h123456), 4'h0, 1, 1);
    send(2'b11, z, z, 8'h88, pk(24'd710, 24'd710, 24'd710, 24'd710), 4'h0, 1, 1);
    send(2'b01, pk(24'd5, 24'hFFFFF9, 24'd0, 24'd2048),
                pk(24'hFFFFF9, 24'hFFFF9C, 24'd0, 24'd0), 8'h99,
                pk(24'd5, 24'hFFFFF9, 24'd0, 24'd2048), 4'h0, 1, 1);
    drain();

    // LUT write in the same cycle as the stage-2 read returns the old entry.
    send(2'b00, z, z, 8'hA0, pk(24'd710, 24'd710, 24'd710, 24'd710), 4'h0, 1, 1);
    lut_write(4'd0, 10'd500);
    send(2'b00, z, z, 8'hA1, pk(24'd500, 24'd500, 24'd500, 24'd500), 4'h0, 1, 1);
    drain();

    // Backpressure: 6 beats, i_ready low for 5 cycles starting 2 cycles in.
    saw_low = 0;
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          logic [95:0] v;
          v = pk(24'(k*16), 24'(k*16+1), 24'(k*16+2), 24'(k*16+3));
          send(2'b01, v, z, 8'(k), v, 4'h0, 1, 0);
        end
      end
      begin
        repeat (2) @(posedge i_clk);
        #1 i_ready = 1'b0;
        repeat (5) @(posedge i_clk);
        #1 i_ready = 1'b1;
      end
      begin
        repeat (12) begin
          @(negedge i_clk);
          if (o_ready === 1'b0) saw_low = 1;
        end
      end
    join
    chk("ready_drop", saw_low, 1);
    drain();

    // Mid-stream reset drops two in-flight beats and clears the LUT.
    send(2'b00, z, z, 8'hE1, z, 4'h0, 0, 0);
    send(2'b00, z, z, 8'hE2, z, 4'h0, 0, 0);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    chk("rst_flush_valid", o_valid, 0);
    repeat (6) @(posedge i_clk);
    #1;
    send(2'b00, z, z, 8'hF0, z, 4'h0, 1, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
